// File: rtl/adder_bist_pkg.sv
// Shared types, directed vectors and LFSR step
// for the 32-bit adder BIST controller.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
  } vec_t;

  localparam int NUM_DIRECTED = 10;

  // Galois taps 32,22,2,1
  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  localparam vec_t DIRECTED [NUM_DIRECTED] = '{
    '{32'hAAAAAAAA, 32'h55555555, 1'b0},
    '{32'h00000000, 32'h00000000, 1'b0},
    '{32'h00000000, 32'h00000000, 1'b1},
    '{32'h00000001, 32'h00000000, 1'b0},
    '{32'h00000000, 32'h00000001, 1'b0},
    '{32'h00000001, 32'h00000001, 1'b1},
    '{32'h80000000, 32'h00000000, 1'b0},
    '{32'h00000000, 32'h80000000, 1'b0},
    '{32'h00000000, 32'h80000000, 1'b1},
    '{32'h80000000, 32'h80000000, 1'b1}
  };

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] s
  );
    return {1'b0, s[31:1]} ^
           (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/adder_bist_lfsr.sv
// Pseudo-random operand source: reseeds on load,
// steps three times per random vector.
module adder_bist_lfsr
  import adder_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [31:0] l1_o,
  output logic [31:0] l2_o,
  output logic        l3b_o
);

  // A zero seed would lock the register at zero
  localparam logic [31:0] SEED_N =
    (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] state_q;
  logic [31:0] l3;

  assign l1_o  = lfsr_next(state_q);
  assign l2_o  = lfsr_next(l1_o);
  assign l3    = lfsr_next(l2_o);
  assign l3b_o = l3[0];

  // Seed on reset/start, jump to L3 per random vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED_N;
    end else if (load_i) begin
      state_q <= SEED_N;
    end else if (adv_i) begin
      state_q <= l3;
    end
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// On-fabric stimulus generator and response checker
// for the 32-bit full adder.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int          NUM_RANDOM    = 50,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [31:0] LFSR_SEED     = 32'h1,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             global_resetn,
  input  logic             start,
  input  logic [31:0]      sum,
  input  logic             cout,
  output logic [31:0]      a,
  output logic [31:0]      b,
  output logic             cin,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [15:0]      first_fail_idx,
  output logic [32:0]      first_fail_res
);

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SET_INIT =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LAST_IDX =
    16'(NUM_DIRECTED + NUM_RANDOM - 1);
  localparam logic [15:0] NDIR =
    16'(NUM_DIRECTED);

  state_e            state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              cin_q, cin_d;
  logic [15:0]       idx_q, idx_d;
  logic [SW-1:0]     set_q, set_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic [15:0]       ffi_q, ffi_d;
  logic [32:0]       ffr_q, ffr_d;

  logic              lfsr_load;
  logic              lfsr_adv;
  logic [31:0]       l1, l2;
  logic              l3b;
  logic [32:0]       res, expv;
  logic [15:0]       nxt_idx;
  vec_t              nxt_vec;

  adder_bist_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (global_resetn),
    .load_i (lfsr_load),
    .adv_i  (lfsr_adv),
    .l1_o   (l1),
    .l2_o   (l2),
    .l3b_o  (l3b)
  );

  assign res  = {cout, sum};
  assign expv = {1'b0, a_q} + {1'b0, b_q}
              + {32'h0, cin_q};

  assign nxt_idx = idx_q + 16'd1;

  // Next vector: table while directed, LFSR after
  always_comb begin
    nxt_vec = '{l1, l2, l3b};
    if (nxt_idx < NDIR) begin
      nxt_vec = DIRECTED[nxt_idx[3:0]];
    end
  end

  // Sequencer next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    idx_d     = idx_q;
    set_d     = set_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ffi_d     = ffi_q;
    ffr_d     = ffr_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          a_d       = DIRECTED[0].a;
          b_d       = DIRECTED[0].b;
          cin_d     = DIRECTED[0].cin;
          idx_d     = '0;
          set_d     = SET_INIT;
          pass_d    = '0;
          fail_d    = '0;
          ffi_d     = '0;
          ffr_d     = '0;
          lfsr_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (set_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          set_d = set_q - 1'b1;
        end
      end
      ST_CHECK: begin
        if (res == expv) begin
          if (pass_q != '1) pass_d = pass_q + 1'b1;
        end else begin
          if (fail_q != '1) fail_d = fail_q + 1'b1;
          if (fail_q == '0) begin
            ffi_d = idx_q;
            ffr_d = res;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_SETTLE;
          idx_d    = nxt_idx;
          set_d    = SET_INIT;
          a_d      = nxt_vec.a;
          b_d      = nxt_vec.b;
          cin_d    = nxt_vec.cin;
          lfsr_adv = (nxt_idx >= NDIR);
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      idx_q   <= '0;
      set_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
      ffr_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      idx_q   <= idx_d;
      set_q   <= set_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      ffr_q   <= ffr_d;
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign cin            = cin_q;
  assign busy           = (state_q == ST_SETTLE) ||
                          (state_q == ST_CHECK);
  assign done           = (state_q == ST_DONE);
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_res = ffr_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: correct and faulty
// adder models, start/reset corner cases.
module tb_adder_bist_ctrl;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
  } tv_t;

  typedef struct {
    int          mode;
    int          dir_pass;
    logic [15:0] ffi;
    logic [32:0] ffr;
  } run_t;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // 0: correct, 1: cout stuck-0, 2: sum[0] stuck-0
  int mode = 0;

  logic        start, start2;
  logic [31:0] sum, sum2, a, a2, b, b2;
  logic        cout, cout2, cin, cin2;
  logic        busy, busy2, done, done2;
  logic [15:0] pass_cnt, fail_cnt, ffi;
  logic [15:0] pass_cnt2, fail_cnt2, ffi2;
  logic [32:0] ffr, ffr2;

  tv_t  vecs [60];
  run_t runs [3];

  function automatic logic [32:0] adder(
    input logic [31:0] x, input logic [31:0] y,
    input logic c, input int m
  );
    logic [32:0] r;
    r = {1'b0, x} + {1'b0, y} + {32'h0, c};
    if (m == 1) r[32] = 1'b0;
    if (m == 2) r[0] = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] nx(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  assign {cout, sum}   = adder(a, b, cin, mode);
  assign {cout2, sum2} = adder(a2, b2, cin2, 0);

  adder_bist_ctrl u_dut (
    .clk            (clk),
    .global_resetn  (rstn),
    .start          (start),
    .sum            (sum),
    .cout           (cout),
    .a              (a),
    .b              (b),
    .cin            (cin),
    .busy           (busy),
    .done           (done),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (ffi),
    .first_fail_res (ffr)
  );

  adder_bist_ctrl #(
    .NUM_RANDOM    (0),
    .SETTLE_CYCLES (1)
  ) u_dut2 (
    .clk            (clk),
    .global_resetn  (rstn),
    .start          (start2),
    .sum            (sum2),
    .cout           (cout2),
    .a              (a2),
    .b              (b2),
    .cin            (cin2),
    .busy           (busy2),
    .done           (done2),
    .pass_cnt       (pass_cnt2),
    .fail_cnt       (fail_cnt2),
    .first_fail_idx (ffi2),
    .first_fail_res (ffr2)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_full(input int r, input bit glitch);
    int ep = 0;
    int ef = 0;
    mode = runs[r].mode;
    for (int k = 0; k < 60; k++) begin
      if (adder(vecs[k].a, vecs[k].b, vecs[k].cin, mode) ==
          adder(vecs[k].a, vecs[k].b, vecs[k].cin, 0))
        ep++;
      else
        ef++;
    end
    pulse_start();
    chk("busy_on_start", busy, 1);
    chk("done_cleared", done, 0);
    for (int k = 0; k < 60; k++) begin
      chk($sformatf("r%0d_vec%0d", r, k), {a, b, cin},
          {vecs[k].a, vecs[k].b, vecs[k].cin});
      if (k == 59) begin
        chk("busy_last", busy, 1);
        chk("done_last", done, 0);
      end
      if (glitch && k == 3) begin
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end else begin
        repeat (5) @(posedge clk);
        #1;
      end
      if (k == 9)
        chk($sformatf("r%0d_dir_pass", r), pass_cnt,
            runs[r].dir_pass);
    end
    chk($sformatf("r%0d_done_at_300", r), done, 1);
    chk($sformatf("r%0d_busy_end", r), busy, 0);
    chk($sformatf("r%0d_pass", r), pass_cnt, ep);
    chk($sformatf("r%0d_fail", r), fail_cnt, ef);
    chk($sformatf("r%0d_ffi", r), ffi, runs[r].ffi);
    chk($sformatf("r%0d_ffr", r), ffr, runs[r].ffr);
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("r%0d_hold", r),
        {done, pass_cnt, fail_cnt}, {1'b1, 16'(ep), 16'(ef)});
  endtask

  task automatic run_small(input string nm);
    int n = 0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    chk({nm, "_clr"}, {done2, pass_cnt2, fail_cnt2}, 0);
    while (!done2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_cycles"}, n, 20);
    chk({nm, "_pass"}, pass_cnt2, 10);
    chk({nm, "_fail"}, fail_cnt2, 0);
  endtask

  initial begin
    logic [31:0] s, l1, l2, l3;
    vecs[0] = '{32'hAAAAAAAA, 32'h55555555, 1'b0};
    vecs[1] = '{32'h0, 32'h0, 1'b0};
    vecs[2] = '{32'h0, 32'h0, 1'b1};
    vecs[3] = '{32'h1, 32'h0, 1'b0};
    vecs[4] = '{32'h0, 32'h1, 1'b0};
    vecs[5] = '{32'h1, 32'h1, 1'b1};
    vecs[6] = '{32'h80000000, 32'h0, 1'b0};
    vecs[7] = '{32'h0, 32'h80000000, 1'b0};
    vecs[8] = '{32'h0, 32'h80000000, 1'b1};
    vecs[9] = '{32'h80000000, 32'h80000000, 1'b1};
    s = 32'h1;
    for (int k = 10; k < 60; k++) begin
      l1 = nx(s);
      l2 = nx(l1);
      l3 = nx(l2);
      vecs[k] = '{l1, l2, l3[0]};
      s = l3;
    end
    runs[0] = '{0, 10, 16'd0, 33'h0};
    runs[1] = '{1, 9, 16'd9, 33'h0_00000001};
    runs[2] = '{2, 3, 16'd0, 33'h0_FFFFFFFE};

    rstn = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs",
        {a, b, cin, busy, done, pass_cnt, fail_cnt},
        0);
    chk("rst_ff", {ffi, ffr}, 0);
    chk("rst_outs2", {a2, b2, cin2, busy2, done2}, 0);
    @(negedge clk) rstn = 1'b1;

    run_full(0, 1'b0);
    run_full(1, 1'b0);
    run_full(2, 1'b0);
    run_full(0, 1'b1);

    mode = 0;
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_vec4", {a, b, cin},
        {vecs[4].a, vecs[4].b, vecs[4].cin});
    chk("pre_rst_pass", pass_cnt, 4);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_ab", {a, b, cin}, 0);
    chk("async_rst_cnt", {pass_cnt, fail_cnt}, 0);
    chk("async_rst_busy", {busy, done}, 0);
    @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    run_full(0, 1'b0);

    run_small("small1");
    run_small("small2");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
